// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keypad receiver: scan-code constants,
// frame/decoder state enums and small decode helpers.
package ps2_pkg;

  localparam int FRAME_DATA_BITS = 8;

  // Scan-code set 2 prefixes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Player 1 keys (non-extended)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Player 2 keys (extended, preceded by E0)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions of the held-key flags
  localparam logic [2:0] KEY_P1_UP    = 3'd0;
  localparam logic [2:0] KEY_P1_DOWN  = 3'd1;
  localparam logic [2:0] KEY_P1_LEFT  = 3'd2;
  localparam logic [2:0] KEY_P1_RIGHT = 3'd3;
  localparam logic [2:0] KEY_P2_UP    = 3'd4;
  localparam logic [2:0] KEY_P2_DOWN  = 3'd5;
  localparam logic [2:0] KEY_P2_LEFT  = 3'd6;
  localparam logic [2:0] KEY_P2_RIGHT = 3'd7;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Maps a scan code to a flag index; bit 3 is the hit flag. Extended codes
  // only match the arrow keys and non-extended codes only match WSAD.
  function automatic logic [3:0] key_index(input logic [7:0] code, input logic ext);
    logic [3:0] res;
    res = 4'b0000;
    if (!ext) begin
      case (code)
        SC_W:    res = {1'b1, KEY_P1_UP};
        SC_S:    res = {1'b1, KEY_P1_DOWN};
        SC_A:    res = {1'b1, KEY_P1_LEFT};
        SC_D:    res = {1'b1, KEY_P1_RIGHT};
        default: res = 4'b0000;
      endcase
    end else begin
      case (code)
        SC_UP:    res = {1'b1, KEY_P2_UP};
        SC_DOWN:  res = {1'b1, KEY_P2_DOWN};
        SC_LEFT:  res = {1'b1, KEY_P2_LEFT};
        SC_RIGHT: res = {1'b1, KEY_P2_RIGHT};
        default:  res = 4'b0000;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes the PS/2 lines, detects
// falling clock edges, deframes start/8 data/odd parity/stop and discards
// frames that stall for TIMEOUT_CYCLES system clocks.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  frame_state_t r_state;
  frame_state_t w_next;

  logic [FRAME_DATA_BITS-1:0] r_shift;
  logic [2:0]                 r_bit_cnt;
  logic                       r_parity;
  logic [CNT_W-1:0]           r_timer;
  logic                       w_timeout;
  logic                       w_accept;
  logic                       w_reject;

  logic [7:0] r_rx_byte;
  logic       r_rx_valid;
  logic       r_rx_err;

  // Synchronizer chains; they reset to the idle-high line level so that
  // leaving reset never looks like a falling clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s  = r_data_sync[SYNC_STAGES-1];
  assign w_fall    = r_clk_prev & ~w_clk_s;
  assign w_timeout = (r_state != FR_IDLE) && (r_timer == CNT_MAX);

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FR_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame next-state logic with the accept/reject decision at the stop bit
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    if (w_timeout) begin
      w_next   = FR_IDLE;
      w_reject = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        FR_IDLE: begin
          if (!w_data_s) begin
            w_next = FR_DATA;
          end
        end
        FR_DATA: begin
          if (r_bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
            w_next = FR_PARITY;
          end
        end
        FR_PARITY: begin
          w_next = FR_STOP;
        end
        FR_STOP: begin
          w_next = FR_IDLE;
          if (w_data_s && odd_parity_ok(r_shift, r_parity)) begin
            w_accept = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
        default: begin
          w_next = FR_IDLE;
        end
      endcase
    end
  end

  // Data shift register, bit counter and parity capture, all on falling edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_fall && !w_timeout) begin
      case (r_state)
        FR_IDLE: begin
          r_bit_cnt <= '0;
        end
        FR_DATA: begin
          r_shift   <= {w_data_s, r_shift[FRAME_DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        FR_PARITY: begin
          r_parity <= w_data_s;
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
    end
  end

  // Stall timer: counts idle cycles inside a frame and saturates at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (r_state == FR_IDLE || w_fall) begin
      r_timer <= '0;
    end else if (r_timer != CNT_MAX) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Registered outputs: byte load and one-cycle valid/error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= w_accept;
      r_rx_err   <= w_reject;
      if (w_accept) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keypad receiver top: frame receiver plus scan-code set 2 make/break
// decoder producing held-key flags for both paddles.
// Optional build macro PS2_LAST_CODE_EN adds last_make/last_make_ext debug
// outputs holding the most recent make code and its extended flag.
module ps2_keypad_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right
`ifdef PS2_LAST_CODE_EN
  ,
  output logic [7:0] last_make,
  output logic       last_make_ext
`endif
);

  logic [7:0] w_rx_byte;
  logic       w_rx_valid;
  logic       w_rx_err;

  dec_state_t r_dec_state;
  dec_state_t w_dec_next;
  logic       w_ext;
  logic       w_brk;
  logic [3:0] w_lookup;
  logic       w_flag_we;
  logic       w_flag_val;
  logic [7:0] r_flags;

`ifdef PS2_LAST_CODE_EN
  logic       w_make;
  logic [7:0] r_last_make;
  logic       r_last_make_ext;
`endif

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_frame_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (w_rx_byte),
    .rx_valid (w_rx_valid),
    .rx_err   (w_rx_err)
  );

  assign w_ext    = (r_dec_state == DEC_EXT) || (r_dec_state == DEC_EXT_BRK);
  assign w_brk    = (r_dec_state == DEC_BRK) || (r_dec_state == DEC_EXT_BRK);
  assign w_lookup = key_index(w_rx_byte, w_ext);

  // Decoder state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec_state <= DEC_BASE;
    end else begin
      r_dec_state <= w_dec_next;
    end
  end

  // Prefix tracking and flag write decision for each received byte
  always_comb begin
    w_dec_next = r_dec_state;
    w_flag_we  = 1'b0;
    w_flag_val = 1'b0;
`ifdef PS2_LAST_CODE_EN
    w_make     = 1'b0;
`endif
    if (w_rx_err) begin
      w_dec_next = DEC_BASE;
    end else if (w_rx_valid) begin
      if (w_rx_byte == SC_EXT && r_dec_state == DEC_BASE) begin
        w_dec_next = DEC_EXT;
      end else if (w_rx_byte == SC_BRK && r_dec_state == DEC_BASE) begin
        w_dec_next = DEC_BRK;
      end else if (w_rx_byte == SC_BRK && r_dec_state == DEC_EXT) begin
        w_dec_next = DEC_EXT_BRK;
      end else begin
        w_dec_next = DEC_BASE;
        w_flag_we  = w_lookup[3];
        w_flag_val = ~w_brk;
`ifdef PS2_LAST_CODE_EN
        w_make     = ~w_brk;
`endif
      end
    end
  end

  // Held-key flags: make sets, break clears, repeats rewrite the same value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (w_flag_we) begin
      r_flags[w_lookup[2:0]] <= w_flag_val;
    end
  end

`ifdef PS2_LAST_CODE_EN
  // Debug capture of the most recent make code and whether it was extended
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_make     <= '0;
      r_last_make_ext <= 1'b0;
    end else if (w_make) begin
      r_last_make     <= w_rx_byte;
      r_last_make_ext <= w_ext;
    end
  end

  assign last_make     = r_last_make;
  assign last_make_ext = r_last_make_ext;
`endif

  assign rx_byte  = w_rx_byte;
  assign rx_valid = w_rx_valid;
  assign rx_err   = w_rx_err;

  assign p1_up    = r_flags[KEY_P1_UP];
  assign p1_down  = r_flags[KEY_P1_DOWN];
  assign p1_left  = r_flags[KEY_P1_LEFT];
  assign p1_right = r_flags[KEY_P1_RIGHT];
  assign p2_up    = r_flags[KEY_P2_UP];
  assign p2_down  = r_flags[KEY_P2_DOWN];
  assign p2_left  = r_flags[KEY_P2_LEFT];
  assign p2_right = r_flags[KEY_P2_RIGHT];

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Self-checking bench for ps2_keypad_rx: directed PS/2 frames, a byte-level
// key model compared every cycle, and literal expectations at key points.
`timescale 1ns/1ps
module tb_ps2_keypad_rx;

  localparam int TO   = 2000;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;
  localparam int HALF = 20;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic ps2Clk  = 1'b1;
  logic ps2Data = 1'b1;

  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxErr;
  logic       p1Up, p1Down, p1Left, p1Right;
  logic       p2Up, p2Down, p2Left, p2Right;
  logic [7:0] dutFlags;

  ps2_keypad_rx #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .rx_byte  (rxByte),
    .rx_valid (rxValid),
    .rx_err   (rxErr),
    .p1_up    (p1Up),
    .p1_down  (p1Down),
    .p1_left  (p1Left),
    .p1_right (p1Right),
    .p2_up    (p2Up),
    .p2_down  (p2Down),
    .p2_left  (p2Left),
    .p2_right (p2Right)
  );

  assign dutFlags = {p2Right, p2Left, p2Down, p2Up, p1Right, p1Left, p1Down, p1Up};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: key flags in order W,S,A,D,Up,Down,Left,Right
  logic [7:0] modelFlags = 8'h00;
  logic [7:0] modelByte  = 8'h00;
  bit         modelExt   = 1'b0;
  bit         modelBrk   = 1'b0;
  logic [7:0] pendByte   = 8'h00;
  int         validAt    = -1;
  int         errAt      = -1;
  int         flagAt     = -1;
  int         prefixClrAt = -1;
  int         lastFallCyc = 0;
  bit         skipErr    = 1'b0;
  int         errors     = 0;
  int         checks     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Key model: prefixes remembered as two bits, keys found by table lookup
  task automatic modelDecode(input logic [7:0] b);
    int idx;
    idx = -1;
    if (b == 8'hE0 && !modelExt && !modelBrk) begin
      modelExt = 1'b1;
    end else if (b == 8'hF0 && !modelBrk) begin
      modelBrk = 1'b1;
    end else begin
      if (!modelExt) begin
        case (b)
          8'h1D: idx = 0;
          8'h1B: idx = 1;
          8'h1C: idx = 2;
          8'h23: idx = 3;
          default: idx = -1;
        endcase
      end else begin
        case (b)
          8'h75: idx = 4;
          8'h72: idx = 5;
          8'h6B: idx = 6;
          8'h74: idx = 7;
          default: idx = -1;
        endcase
      end
      if (idx >= 0) modelFlags[idx] = !modelBrk;
      modelExt = 1'b0;
      modelBrk = 1'b0;
    end
  endtask

  // Drives the first nBits bits of a frame and schedules the model events
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int nBits);
    logic [10:0] f;
    f = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2Data = f[i];
      repeat (HALF/2) @(negedge clk);
      ps2Clk = 1'b0;
      lastFallCyc = cyc;
      if (i == 10) begin
        if (badPar || badStop) begin
          errAt       = cyc + LAT;
          prefixClrAt = cyc + LAT + 1;
        end else begin
          pendByte = b;
          validAt  = cyc + LAT;
          flagAt   = cyc + LAT + 1;
        end
      end
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
    ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0, 11);
  endtask

  // Partial frame followed by a silent line until the stall error appears
  task automatic timeoutWait(input string tag);
    bit seen;
    int lat;
    seen = 1'b0;
    skipErr = 1'b1;
    applyStimulus(8'h55, 1'b0, 1'b0, 5);
    for (int w = 0; w < TO + 300; w++) begin
      @(negedge clk);
      if (rxErr) begin
        seen = 1'b1;
        break;
      end
    end
    lat = cyc - lastFallCyc;
    checkOutput({tag, "_err_seen"}, seen, 1);
    checkOutput({tag, "_latency_in_range"}, (lat >= TO) && (lat <= TO + LAT + 3), 1);
    @(negedge clk);
    checkOutput({tag, "_err_one_cycle"}, rxErr, 0);
    modelExt = 1'b0;
    modelBrk = 1'b0;
    skipErr  = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (reset) begin
      if (cyc == validAt) modelByte = pendByte;
      if (cyc == flagAt) modelDecode(pendByte);
      if (cyc == prefixClrAt) begin
        modelExt = 1'b0;
        modelBrk = 1'b0;
      end
      checkOutput("rx_valid", rxValid, cyc == validAt);
      if (!skipErr) checkOutput("rx_err", rxErr, cyc == errAt);
      checkOutput("rx_byte", rxByte, modelByte);
      checkOutput("flags", dutFlags, modelFlags);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_state", {rxByte, rxValid, rxErr, dutFlags}, 0);
    #3 reset = 1'b1;
    repeat (10) @(negedge clk);

    // Make and break of W
    sendByte(8'h1D);
    checkOutput("lit_w_make", dutFlags, 8'h01);
    checkOutput("lit_w_byte", rxByte, 8'h1D);
    sendByte(8'hF0);
    sendByte(8'h1D);
    checkOutput("lit_w_break", dutFlags, 8'h00);

    // Extended up, plain A, extended break of up, bare 0x75
    sendByte(8'hE0);
    sendByte(8'h75);
    checkOutput("lit_up_make", dutFlags, 8'h10);
    sendByte(8'h1C);
    checkOutput("lit_a_make", dutFlags, 8'h14);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    checkOutput("lit_up_break", dutFlags, 8'h04);
    sendByte(8'h75);
    checkOutput("lit_bare_75", dutFlags, 8'h04);

    // Typematic repeat and opposing keys held together
    sendByte(8'h1C);
    checkOutput("lit_repeat", dutFlags, 8'h04);
    sendByte(8'h1D);
    sendByte(8'h1B);
    checkOutput("lit_opposing", dutFlags, 8'h07);
    sendByte(8'hF0);
    sendByte(8'h1D);
    sendByte(8'hF0);
    sendByte(8'h1B);

    // Unmapped codes consume the prefix
    sendByte(8'hE0);
    sendByte(8'hAA);
    sendByte(8'h75);
    sendByte(8'hFA);
    checkOutput("lit_unmapped", dutFlags, 8'h04);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkOutput("lit_a_break", dutFlags, 8'h00);

    // Parity and stop errors
    sendByte(8'hAA);
    applyStimulus(8'h1C, 1'b1, 1'b0, 11);
    checkOutput("lit_badpar_flags", dutFlags, 8'h00);
    checkOutput("lit_badpar_byte", rxByte, 8'hAA);
    sendByte(8'hE0);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    sendByte(8'h75);
    checkOutput("lit_err_drops_prefix", dutFlags, 8'h00);
    sendByte(8'h1C);
    checkOutput("lit_a_after_err", dutFlags, 8'h04);

    // Stalled frames
    timeoutWait("timeout1");
    sendByte(8'h23);
    checkOutput("lit_d_after_timeout", dutFlags, 8'h0C);
    sendByte(8'hE0);
    timeoutWait("timeout2");
    sendByte(8'h75);
    checkOutput("lit_timeout_drops_prefix", dutFlags, 8'h0C);
    sendByte(8'hF0);
    sendByte(8'h1C);
    sendByte(8'hF0);
    sendByte(8'h23);

    // Reset in the middle of a frame
    sendByte(8'hE0);
    sendByte(8'h6B);
    checkOutput("lit_left_make", dutFlags, 8'h40);
    applyStimulus(8'h1D, 1'b0, 1'b0, 4);
    ps2Clk  = 1'b0;
    ps2Data = 1'b0;
    @(negedge clk);
    #3 reset = 1'b0;
    modelFlags  = 8'h00;
    modelByte   = 8'h00;
    modelExt    = 1'b0;
    modelBrk    = 1'b0;
    validAt     = -1;
    errAt       = -1;
    flagAt      = -1;
    prefixClrAt = -1;
    #1;
    checkOutput("reset_mid_frame", {rxByte, rxValid, rxErr, dutFlags}, 0);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (5) @(negedge clk);
    #3 reset = 1'b1;
    repeat (10) @(negedge clk);
    sendByte(8'hE0);
    sendByte(8'h6B);
    checkOutput("lit_left_after_reset", dutFlags, 8'h40);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keypad_rx.md
Name: ps2_keypad_rx

Overview:
- PS/2 keyboard receiver; the input side that feeds the VGA game's paddle controls.
- Samples the board's ps2_clk/ps2_data lines and deframes 11-bit device-to-host frames.
- Decodes scan-code set 2 make/break sequences into held-key flags p1_up..p2_right, which drive the paddle movement logic.
- Receive-only: the block never drives ps2_clk or ps2_data.

Parameters:
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the partial frame is discarded (1 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronizers (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  PS/2 clock line, asynchronous, read only.
- ps2_data  input  1  PS/2 data line, asynchronous, read only.
- rx_byte  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse: rx_byte updated.
- rx_err  output  1  one-cycle pulse on parity error, stop error or timeout.
- p1_up, p1_down, p1_left, p1_right  output  1 each  held flags for keys W, S, A, D.
- p2_up, p2_down, p2_left, p2_right  output  1 each  held flags for the arrow keys.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, frame FSM in IDLE, decoder in BASE, timeout counter 0.
- Synchronizers: both lines pass through SYNC_STAGES FFs. A falling edge is detected when synced ps2_clk goes 1 then 0. Line edge to internal sample takes SYNC_STAGES+1 clk cycles.
- Frame FSM (bit samples are taken on detected falling edges only):
  - IDLE: data=0 -> DATA; data=1 (bad start bit) -> stay in IDLE, no error.
  - DATA: shifts 8 bits LSB first; a 3-bit counter wraps 7 -> 0, then -> PARITY.
  - PARITY: stores the bit -> STOP.
  - STOP: accept when stop=1 and odd parity holds over the 8 data bits plus the parity bit. Accept loads rx_byte and pulses rx_valid the next cycle. Otherwise pulse rx_err and leave rx_byte unchanged. Either way -> IDLE.
- Timeout:
  - The counter runs while the FSM is not in IDLE and clears on every detected falling edge.
  - Reaching TIMEOUT_CYCLES -> IDLE, rx_err pulse, decoder -> BASE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- Decoder (acts on rx_valid; flags update one cycle after the rx_valid pulse):
  - States: BASE, EXT, BRK, EXT_BRK.
  - 0xE0: BASE -> EXT.
  - 0xF0: BASE -> BRK; EXT -> EXT_BRK.
  - Any other byte: acted on per the rules below, then -> BASE.
  - BASE or EXT with a mapped code sets its flag (make). BRK or EXT_BRK with a mapped code clears its flag (break).
  - Player 1 codes (non-extended): 0x1D up, 0x1B down, 0x1C left, 0x23 right.
  - Player 2 codes (extended): E0 75 up, E0 72 down, E0 6B left, E0 74 right.
  - A non-extended code is never treated as an arrow key, and an extended code is never treated as a player-1 key.
  - Unmapped codes (including 0xAA and 0xFA) change no flag but still consume the prefix.
  - Typematic repeats re-set an already-set flag; no visible change.
- rx_err also returns the decoder to BASE and leaves flags unchanged.
- Opposing keys held together (for example p1_up and p1_down) are both reported as 1; arbitration belongs to the consumer.
- Reset mid-frame: the partial frame is discarded and all flags clear.

Optional Feature:
- Macro: PS2_LAST_CODE_EN.
- Defined: adds output last_make[7:0] plus last_make_ext (1), holding the most recent make code and whether it was extended. Both reset to 0. They feed segment_decoder for on-board debug.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants (SC_EXT=0xE0, SC_BRK=0xF0, SC_W, SC_S, SC_A, SC_D, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT);
  - FRAME_DATA_BITS=8;
  - the frame FSM and decoder state enums.
- Sub-module ps2_frame_rx holds synchronizers, edge detection, frame FSM and timeout, and outputs rx_byte/rx_valid/rx_err.
- Top level ps2_keypad_rx holds the decoder FSM and the flag registers.

Test Plan:
- Frame 0x1D with correct parity -> rx_valid pulse, rx_byte=0x1D, p1_up=1 one cycle later, all other flags 0.
- Byte sequence F0 1D after the make -> p1_up=0, rx_err never asserted.
- Sequences E0 75, then 1C, then E0 F0 75 -> p2_up 1->0 and p1_left=1. A bare 0x75 sets nothing.
- Frame 0x1C with inverted parity -> rx_err pulse, no rx_valid, p1_left stays 0. The next good 0x1C sets p1_left=1.
- 5 bits of a frame, then line idle for 100000 cycles -> rx_err pulse and FSM back in IDLE. The following full 0x23 frame sets p1_right=1.
- reset=0 asserted mid-frame while p2_left=1 -> all outputs 0 immediately. After release, frame E0 then 6B -> p2_left=1.
